fl_distributor_mcast: RTL and testbench
=======================================

// Module: fl_distributor_mcast
// PURPOSE
//  FrameLink 1:N distributor with unicast and multicast routing. Reads a selection field from the
//  first word of each frame and forks the whole frame to one or more TX ports. Zero-latency
//  handshake fork with per-port done tracking; unroutable frames are dropped and counted.
//  Sits behind the RX frame buffers, feeding per-interface processing pipelines.
// PARAMETERS
//  DATA_WIDTH   64  FrameLink data width in bits; multiple of 8
//  REM_WIDTH    3   log2(DATA_WIDTH/8)
//  OUTPUTS      4   number of TX ports, 2..16
//  SEL_WIDTH    2   index field width, log2(OUTPUTS) rounded up; used when MASK_MODE=0
//  MASK_MODE    0   0 = index field selects one port; 1 = OUTPUTS-bit one-hot/multi-hot mask
//  DEFAULT_IFC  0   port used when index >= OUTPUTS (MASK_MODE=0 only)
//  INUM_OFFSET  0   bit offset of the selection field within the SOF word
// PORTS
//  CLK            in   1                 clock
//  RESET_N        in   1                 asynchronous active-low reset
//  RX_DATA        in   DATA_WIDTH        input data
//  RX_REM         in   REM_WIDTH         valid bytes - 1 in EOP word
//  RX_SOF_N       in   1                 start of frame
//  RX_EOF_N       in   1                 end of frame
//  RX_SOP_N       in   1                 start of part
//  RX_EOP_N       in   1                 end of part
//  RX_SRC_RDY_N   in   1                 RX word valid
//  RX_DST_RDY_N   out  1                 RX word accepted
//  TX_DATA        out  OUTPUTS*DATA_WIDTH  port i at [i*DATA_WIDTH +: DATA_WIDTH]
//  TX_REM         out  OUTPUTS*REM_WIDTH   per-port REM
//  TX_SOF_N/TX_EOF_N/TX_SOP_N/TX_EOP_N  out  OUTPUTS  per-port framing
//  TX_SRC_RDY_N   out  OUTPUTS           per-port valid
//  TX_DST_RDY_N   in   OUTPUTS           per-port ready
//  DROP_CNT       out  16                dropped-frame counter, saturating
// BEHAVIOUR
//  - Reset: state=IDLE, sel_reg=0, done=0, DROP_CNT=0; all TX_SRC_RDY_N=1, RX_DST_RDY_N=1.
//  - TX data, REM and framing are RX values broadcast to every port; only SRC_RDY_N is per-port.
//  - Selection (SOF word, IDLE): MASK_MODE=0: idx=RX_DATA[INUM_OFFSET+:SEL_WIDTH];
//    sel=1<<idx, or 1<<DEFAULT_IFC if idx>=OUTPUTS. MASK_MODE=1: sel=RX_DATA[INUM_OFFSET+:OUTPUTS].
//    SOF word uses sel combinationally; sel_reg captures it when the SOF word is consumed.
//  - Fork: TX_SRC_RDY_N[i]=0 iff RX valid & sel[i] & !done[i]. acc[i]=!TX_SRC_RDY_N[i]&!TX_DST_RDY_N[i].
//    Word consumed (RX_DST_RDY_N=0) iff for all i in sel: done[i] | acc[i]. On consume done<=0;
//    else done<=done|acc. Each port sees each word exactly once; zero-cycle latency.
//  - FSM:
//    IDLE: valid SOF & sel!=0 -> FWD on consume (stays IDLE if word also has EOF).
//          valid SOF & sel==0 -> word consumed, DROP_CNT++ (sat 0xFFFF); -> DROP unless EOF.
//          valid non-SOF word -> consumed and discarded, not counted.
//    FWD:  sel=sel_reg; consume of EOF word -> IDLE. A SOF inside FWD is forwarded as data.
//    DROP: RX_DST_RDY_N=0, all TX_SRC_RDY_N=1; consume of EOF word -> IDLE.
//  - Stalled port holds the whole fork; no reordering, no buffering beyond done bits.
//  - RX_SRC_RDY_N deasserted mid-word with done partially set: done held until word is re-presented.
//  - Reset mid-frame: immediate return to reset values; remainder of frame is then treated as
//    non-SOF words in IDLE and discarded.
// TESTING
//  - MASK_MODE=0, OUTPUTS=4: 3-word frame idx=2, all ready -> only TX2 sees 3 words, 3 cycles, DROP_CNT=0.
//  - MASK_MODE=0: idx=5 (SEL_WIDTH=3, OUTPUTS=4), DEFAULT_IFC=1 -> frame on TX1 only.
//  - MASK_MODE=1: mask=4'b1011, TX1 ready only every 3rd cycle -> TX0,1,3 get identical frames,
//    each word exactly once, RX stalled until TX1 accepts.
//  - MASK_MODE=1: mask=0 on 5-word frame -> RX accepts 5 words back-to-back, no TX valid, DROP_CNT=1;
//    70000 such frames -> DROP_CNT=0xFFFF.
//  - Single-word SOF+EOF frames back-to-back to alternating ports -> one word/cycle, FSM stays IDLE.
//  - RESET_N low in 3rd word of 6-word frame -> outputs at reset values; remaining 3 words
//    discarded; next SOF frame routed correctly.

Source files
------------

// File: rtl/fl_distributor_mcast.sv
// FrameLink 1:N distributor: forks each frame to the TX ports picked from its SOF word
// (index or mask), with per-port done tracking; frames with an empty port set are dropped and counted.
module fl_distributor_mcast #(
  parameter int DATA_WIDTH  = 64,
  parameter int REM_WIDTH   = 3,
  parameter int OUTPUTS     = 4,
  parameter int SEL_WIDTH   = 2,
  parameter int MASK_MODE   = 0,
  parameter int DEFAULT_IFC = 0,
  parameter int INUM_OFFSET = 0
) (
  input  logic                            CLK,
  input  logic                            RESET_N,
  input  logic [DATA_WIDTH-1:0]           RX_DATA,
  input  logic [REM_WIDTH-1:0]            RX_REM,
  input  logic                            RX_SOF_N,
  input  logic                            RX_EOF_N,
  input  logic                            RX_SOP_N,
  input  logic                            RX_EOP_N,
  input  logic                            RX_SRC_RDY_N,
  output logic                            RX_DST_RDY_N,
  output logic [OUTPUTS*DATA_WIDTH-1:0]   TX_DATA,
  output logic [OUTPUTS*REM_WIDTH-1:0]    TX_REM,
  output logic [OUTPUTS-1:0]              TX_SOF_N,
  output logic [OUTPUTS-1:0]              TX_EOF_N,
  output logic [OUTPUTS-1:0]              TX_SOP_N,
  output logic [OUTPUTS-1:0]              TX_EOP_N,
  output logic [OUTPUTS-1:0]              TX_SRC_RDY_N,
  input  logic [OUTPUTS-1:0]              TX_DST_RDY_N,
  output logic [15:0]                     DROP_CNT
);

  typedef enum logic [1:0] {IDLE = 2'd0, FWD = 2'd1, DROP = 2'd2} state_t;

  state_t               state_r, state_nxt_s;
  logic [OUTPUTS-1:0]   sel_r, done_r, sof_sel_s, route_s, tx_vld_s, acc_s;
  logic [15:0]          drop_cnt_r;
  logic                 rx_vld_s, all_ok_s, consume_s, sof_s, eof_s;
  logic                 drop_inc_s, cap_sel_s;

  // Reset also masks RX valid so the handshake outputs sit idle while reset is held
  assign rx_vld_s = ~RX_SRC_RDY_N & RESET_N;
  assign sof_s    = ~RX_SOF_N;
  assign eof_s    = ~RX_EOF_N;

  generate
    if (MASK_MODE != 0) begin : g_mask
      assign sof_sel_s = RX_DATA[INUM_OFFSET +: OUTPUTS];
    end else begin : g_idx
      logic [SEL_WIDTH-1:0] idx_s;
      assign idx_s = RX_DATA[INUM_OFFSET +: SEL_WIDTH];
      // Index decode; out-of-range indices fall back to the default port
      always_comb begin
        sof_sel_s = '0;
        if (int'(idx_s) >= OUTPUTS) begin
          sof_sel_s[DEFAULT_IFC] = 1'b1;
        end else begin
          for (int i = 0; i < OUTPUTS; i++) begin
            sof_sel_s[i] = (int'(idx_s) == i);
          end
        end
      end
    end
  endgenerate

  // Port set the current word is forked to
  always_comb begin
    route_s = '0;
    case (state_r)
      IDLE:    if (sof_s) route_s = sof_sel_s; else route_s = '0;
      FWD:     route_s = sel_r;
      DROP:    route_s = '0;
      default: route_s = '0;
    endcase
  end

  // A word retires once every selected port has taken it, now or on an earlier cycle
  assign tx_vld_s  = {OUTPUTS{rx_vld_s}} & route_s & ~done_r;
  assign acc_s     = tx_vld_s & ~TX_DST_RDY_N;
  assign all_ok_s  = &(~route_s | done_r | acc_s);
  assign consume_s = rx_vld_s & all_ok_s;

  assign RX_DST_RDY_N = (state_r == DROP) ? 1'b0 : ~consume_s;
  assign TX_SRC_RDY_N = ~tx_vld_s;
  assign TX_DATA      = {OUTPUTS{RX_DATA}};
  assign TX_REM       = {OUTPUTS{RX_REM}};
  assign TX_SOF_N     = {OUTPUTS{RX_SOF_N}};
  assign TX_EOF_N     = {OUTPUTS{RX_EOF_N}};
  assign TX_SOP_N     = {OUTPUTS{RX_SOP_N}};
  assign TX_EOP_N     = {OUTPUTS{RX_EOP_N}};
  assign DROP_CNT     = drop_cnt_r;

  // Next-state logic; non-SOF words in IDLE retire with an empty route and change nothing
  always_comb begin
    state_nxt_s = state_r;
    drop_inc_s  = 1'b0;
    cap_sel_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (consume_s && sof_s) begin
          if (sof_sel_s != '0) begin
            cap_sel_s   = 1'b1;
            state_nxt_s = eof_s ? IDLE : FWD;
          end else begin
            drop_inc_s  = 1'b1;
            state_nxt_s = eof_s ? IDLE : DROP;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FWD, DROP: begin
        if (consume_s && eof_s) state_nxt_s = IDLE;
        else state_nxt_s = state_r;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_r <= IDLE;
    else state_r <= state_nxt_s;
  end

  // Frame port set, per-port done bits and saturating drop counter
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sel_r      <= '0;
      done_r     <= '0;
      drop_cnt_r <= 16'd0;
    end else begin
      if (cap_sel_s) sel_r <= sof_sel_s;
      done_r <= consume_s ? '0 : (done_r | acc_s);
      if (drop_inc_s && (drop_cnt_r != 16'hFFFF)) drop_cnt_r <= drop_cnt_r + 16'd1;
    end
  end

endmodule

// File: tb/tb_fl_distributor_mcast.sv
// Bench for fl_distributor_mcast: an index-mode instance (SEL_WIDTH=3, DEFAULT_IFC=1) and a
// mask-mode instance (mask at bit 4), checked against a frame-level routing model.
module tb_fl_distributor_mcast;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [63:0]   rx_data = 64'd0;
  logic [2:0]    rx_rem = 3'd0;
  logic          rx_sof_n = 1'b1, rx_eof_n = 1'b1, rx_sop_n = 1'b1, rx_eop_n = 1'b1;
  logic          vld0_n = 1'b1, vld1_n = 1'b1;
  logic [3:0]    tx_rdy_n = 4'd0;
  logic          dst0_n, dst1_n;
  logic [255:0]  tx_data0, tx_data1;
  logic [11:0]   tx_rem0, tx_rem1;
  logic [3:0]    sof0, eof0, sop0, eop0, src0;
  logic [3:0]    sof1, eof1, sop1, eop1, src1;
  logic [15:0]   drop0, drop1;

  logic          act = 1'b0;
  int            rdy_mode = 0;
  int            cyc_g = 0;
  int            errors = 0;
  int            checks = 0;
  int            vld_seen = 0;
  logic [15:0]   exp_drop = 16'd0;
  logic [63:0]   got [4][$];
  logic [63:0]   exp [4][$];

  wire [3:0]   src_act  = act ? src1 : src0;
  wire [255:0] data_act = act ? tx_data1 : tx_data0;
  wire         rx_acc   = act ? ~dst1_n : ~dst0_n;
  wire [15:0]  drop_act = act ? drop1 : drop0;

  always #5 clk = ~clk;

  fl_distributor_mcast #(.DATA_WIDTH(64), .REM_WIDTH(3), .OUTPUTS(4), .SEL_WIDTH(3),
    .MASK_MODE(0), .DEFAULT_IFC(1), .INUM_OFFSET(0)) dut0 (
    .CLK(clk), .RESET_N(rst_n), .RX_DATA(rx_data), .RX_REM(rx_rem),
    .RX_SOF_N(rx_sof_n), .RX_EOF_N(rx_eof_n), .RX_SOP_N(rx_sop_n), .RX_EOP_N(rx_eop_n),
    .RX_SRC_RDY_N(vld0_n), .RX_DST_RDY_N(dst0_n), .TX_DATA(tx_data0), .TX_REM(tx_rem0),
    .TX_SOF_N(sof0), .TX_EOF_N(eof0), .TX_SOP_N(sop0), .TX_EOP_N(eop0),
    .TX_SRC_RDY_N(src0), .TX_DST_RDY_N(tx_rdy_n), .DROP_CNT(drop0));

  fl_distributor_mcast #(.DATA_WIDTH(64), .REM_WIDTH(3), .OUTPUTS(4), .SEL_WIDTH(2),
    .MASK_MODE(1), .DEFAULT_IFC(0), .INUM_OFFSET(4)) dut1 (
    .CLK(clk), .RESET_N(rst_n), .RX_DATA(rx_data), .RX_REM(rx_rem),
    .RX_SOF_N(rx_sof_n), .RX_EOF_N(rx_eof_n), .RX_SOP_N(rx_sop_n), .RX_EOP_N(rx_eop_n),
    .RX_SRC_RDY_N(vld1_n), .RX_DST_RDY_N(dst1_n), .TX_DATA(tx_data1), .TX_REM(tx_rem1),
    .TX_SOF_N(sof1), .TX_EOF_N(eof1), .TX_SOP_N(sop1), .TX_EOP_N(eop1),
    .TX_SRC_RDY_N(src1), .TX_DST_RDY_N(tx_rdy_n), .DROP_CNT(drop1));

  // Record every word each port of the active instance accepts on the coming edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (src_act != 4'hF) vld_seen++;
      for (int p = 0; p < 4; p++)
        if (!src_act[p] && !tx_rdy_n[p]) got[p].push_back(data_act[p*64 +: 64]);
    end
  end

  // Port set a frame must reach, from its first word
  function automatic logic [3:0] model_route(input logic a, input logic [63:0] w);
    if (a) return w[7:4];
    if (w[2:0] < 3'd4) return 4'b0001 << w[2:0];
    return 4'b0010;
  endfunction

  task automatic update_rdy();
    cyc_g++;
    case (rdy_mode)
      1:       tx_rdy_n = 4'($urandom_range(0, 15));
      2:       tx_rdy_n = (cyc_g % 3 == 0) ? 4'b0000 : 4'b0010;
      default: tx_rdy_n = 4'b0000;
    endcase
  endtask

  task automatic drive_word(input logic [63:0] w, input logic sof, input logic eof, output int c);
    bit fin = 0;
    rx_data = w; rx_rem = 3'($urandom_range(0, 7));
    rx_sof_n = ~sof; rx_eof_n = ~eof; rx_sop_n = ~sof; rx_eop_n = ~eof;
    if (act) vld1_n = 1'b0; else vld0_n = 1'b0;
    c = 0;
    while (!fin) begin
      @(negedge clk);
      c++;
      if (rx_acc) fin = 1;
      else if (c >= 300) begin
        checks++; errors++; fin = 1;
        $display("FAIL drive_timeout: word %h not accepted after %0d cycles, required accept", w, c);
      end
      @(posedge clk); #1;
      update_rdy();
    end
    vld0_n = 1'b1; vld1_n = 1'b1;
  endtask

  task automatic send_frame(input int n, input logic [3:0] fld, output int cyc);
    logic [63:0] w;
    logic [3:0]  s = 4'd0;
    int c;
    cyc = 0;
    for (int k = 0; k < n; k++) begin
      w = {$urandom, $urandom};
      if (k == 0) begin
        if (act) w[7:4] = fld; else w[2:0] = fld[2:0];
        s = model_route(act, w);
        if (s == 4'd0 && exp_drop != 16'hFFFF) exp_drop++;
      end
      for (int p = 0; p < 4; p++) if (s[p]) exp[p].push_back(w);
      drive_word(w, k == 0, k == n - 1, c);
      cyc += c;
    end
  endtask

  task automatic do_reset();
    vld0_n = 1'b1; vld1_n = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int p = 0; p < 4; p++) begin got[p].delete(); exp[p].delete(); end
    exp_drop = 16'd0; vld_seen = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx_data = 64'h0000_0000_0000_00F2; rx_sof_n = 1'b0; rx_eof_n = 1'b1;
    vld0_n = 1'b0; vld1_n = 1'b0;
    @(posedge clk); #1;
    checks += 4;
    if (dst0_n !== 1'b1) begin errors++; $display("FAIL rst_dst0: got %b required 1", dst0_n); end
    if (src0 !== 4'hF) begin errors++; $display("FAIL rst_src0: got %b required 1111", src0); end
    if (dst1_n !== 1'b1) begin errors++; $display("FAIL rst_dst1: got %b required 1", dst1_n); end
    if (src1 !== 4'hF) begin errors++; $display("FAIL rst_src1: got %b required 1111", src1); end
    do_reset();
    checks += 2;
    if (drop0 !== 16'd0) begin errors++; $display("FAIL rst_drop0: got %0d required 0", drop0); end
    if (drop1 !== 16'd0) begin errors++; $display("FAIL rst_drop1: got %0d required 0", drop1); end
  endtask

  task automatic test_unicast();
    int cyc;
    act = 1'b0; rdy_mode = 0; do_reset();
    send_frame(3, 4'd2, cyc);
    checks += 3;
    if (cyc !== 3) begin errors++; $display("FAIL uni_cycles: got %0d required 3", cyc); end
    if (drop0 !== 16'd0) begin errors++; $display("FAIL uni_drop: got %0d required 0", drop0); end
    if (tx_data0[3*64 +: 64] !== rx_data || sof0 !== {4{rx_sof_n}}) begin
      errors++; $display("FAIL uni_broadcast: got %h/%b required %h/%b", tx_data0[3*64 +: 64], sof0, rx_data, {4{rx_sof_n}});
    end
    send_frame(2, 4'd5, cyc);
    send_frame(1, 4'd7, cyc);
    rdy_mode = 1;
    for (int f = 0; f < 12; f++) send_frame($urandom_range(1, 4), 4'($urandom_range(0, 7)), cyc);
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (got[p].size() !== exp[p].size()) begin
        errors++; $display("FAIL uni_port%0d_words: got %0d required %0d", p, got[p].size(), exp[p].size());
      end else begin
        for (int k = 0; k < exp[p].size(); k++)
          if (got[p][k] !== exp[p][k]) begin
            errors++; $display("FAIL uni_port%0d_word%0d: got %h required %h", p, k, got[p][k], exp[p][k]);
          end
      end
    end
  endtask

  task automatic test_mcast();
    int cyc;
    act = 1'b1; rdy_mode = 2; do_reset();
    send_frame(4, 4'b1011, cyc);
    checks++;
    if (cyc < 10) begin errors++; $display("FAIL mc_stall_cycles: got %0d required >= 10", cyc); end
    rdy_mode = 1;
    for (int f = 0; f < 12; f++) send_frame($urandom_range(1, 4), 4'($urandom_range(1, 15)), cyc);
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (got[p].size() !== exp[p].size()) begin
        errors++; $display("FAIL mc_port%0d_words: got %0d required %0d", p, got[p].size(), exp[p].size());
      end else begin
        for (int k = 0; k < exp[p].size(); k++)
          if (got[p][k] !== exp[p][k]) begin
            errors++; $display("FAIL mc_port%0d_word%0d: got %h required %h", p, k, got[p][k], exp[p][k]);
          end
      end
    end
    checks++;
    if (drop1 !== exp_drop) begin errors++; $display("FAIL mc_drop: got %0d required %0d", drop1, exp_drop); end
  endtask

  task automatic test_drop();
    int cyc;
    act = 1'b1; rdy_mode = 1; do_reset();
    send_frame(5, 4'b0000, cyc);
    checks += 3;
    if (cyc !== 5) begin errors++; $display("FAIL drop_cycles: got %0d required 5", cyc); end
    if (vld_seen !== 0) begin errors++; $display("FAIL drop_tx_valid: got %0d valid cycles required 0", vld_seen); end
    if (drop1 !== 16'd1) begin errors++; $display("FAIL drop_count: got %0d required 1", drop1); end
    drive_word({$urandom, $urandom} | 64'hF0, 1'b0, 1'b1, cyc);
    checks += 3;
    if (cyc !== 1) begin errors++; $display("FAIL stray_cycles: got %0d required 1", cyc); end
    if (vld_seen !== 0) begin errors++; $display("FAIL stray_tx_valid: got %0d required 0", vld_seen); end
    if (drop1 !== 16'd1) begin errors++; $display("FAIL stray_count: got %0d required 1", drop1); end
  endtask

  task automatic test_back_to_back();
    int cyc, tot;
    act = 1'b0; rdy_mode = 0; do_reset();
    tot = 0;
    for (int f = 0; f < 8; f++) begin
      send_frame(1, (f % 2 == 0) ? 4'd0 : 4'd3, cyc);
      tot += cyc;
    end
    checks++;
    if (tot !== 8) begin errors++; $display("FAIL b2b_cycles: got %0d required 8", tot); end
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (got[p].size() !== exp[p].size()) begin
        errors++; $display("FAIL b2b_port%0d_words: got %0d required %0d", p, got[p].size(), exp[p].size());
      end else begin
        for (int k = 0; k < exp[p].size(); k++)
          if (got[p][k] !== exp[p][k]) begin
            errors++; $display("FAIL b2b_port%0d_word%0d: got %h required %h", p, k, got[p][k], exp[p][k]);
          end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] w;
    int c, tot;
    act = 1'b0; rdy_mode = 0; do_reset();
    for (int k = 0; k < 2; k++) begin
      w = {$urandom, $urandom};
      if (k == 0) w[2:0] = 3'd3;
      exp[3].push_back(w);
      drive_word(w, k == 0, 1'b0, c);
    end
    rx_data = {$urandom, $urandom}; rx_sof_n = 1'b1; rx_eof_n = 1'b1; vld0_n = 1'b0;
    rst_n = 1'b0;
    #1;
    checks += 2;
    if (dst0_n !== 1'b1) begin errors++; $display("FAIL midrst_dst: got %b required 1", dst0_n); end
    if (src0 !== 4'hF) begin errors++; $display("FAIL midrst_src: got %b required 1111", src0); end
    @(posedge clk); #1;
    rst_n = 1'b1; vld0_n = 1'b1; vld_seen = 0;
    tot = 0;
    for (int k = 3; k < 6; k++) begin
      drive_word({$urandom, $urandom}, 1'b0, k == 5, c);
      tot += c;
    end
    checks += 3;
    if (tot !== 3) begin errors++; $display("FAIL midrst_discard_cycles: got %0d required 3", tot); end
    if (vld_seen !== 0) begin errors++; $display("FAIL midrst_discard_valid: got %0d required 0", vld_seen); end
    if (drop0 !== 16'd0) begin errors++; $display("FAIL midrst_drop: got %0d required 0", drop0); end
    send_frame(2, 4'd0, c);
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (got[p].size() !== exp[p].size()) begin
        errors++; $display("FAIL midrst_port%0d_words: got %0d required %0d", p, got[p].size(), exp[p].size());
      end else begin
        for (int k = 0; k < exp[p].size(); k++)
          if (got[p][k] !== exp[p][k]) begin
            errors++; $display("FAIL midrst_port%0d_word%0d: got %h required %h", p, k, got[p][k], exp[p][k]);
          end
      end
    end
  endtask

  task automatic test_saturate();
    int c;
    act = 1'b1; rdy_mode = 0; do_reset();
    for (int f = 0; f < 65540; f++) begin
      send_frame(1, 4'b0000, c);
      if (f == 65533) begin
        checks++;
        if (drop_act !== exp_drop) begin errors++; $display("FAIL sat_near: got %h required %h", drop_act, exp_drop); end
      end
    end
    checks++;
    if (drop_act !== exp_drop) begin errors++; $display("FAIL sat_final: got %h required %h", drop_act, exp_drop); end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_mcast();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
